// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode/func codes, ALU and forwarding encodings, control word types and main decoder
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;
  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic       sign_zero;
    logic [1:0] aluop;
  } ctrl_t;
  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jrcontrol;
    logic [1:0] aluop;
  } ex_ctrl_t;
  function automatic ctrl_t decode(input logic [5:0] op);
    case (op)
      OP_RTYPE: decode = 11'b100100000_10;
      OP_LW:    decode = 11'b011110000_00;
      OP_SW:    decode = 11'b010001000_00;
      OP_ADDI:  decode = 11'b010100000_00;
      OP_XORI:  decode = 11'b010100001_11;
      OP_BNE:   decode = 11'b000000100_01;
      OP_J:     decode = 11'b000000010_00;
      default:  decode = '0;
    endcase
  endfunction
endpackage

// File: rtl/mips_fwd_select.sv
// mips_fwd_select: operand forwarding select for one ALU source; FWD_R0_GUARD_EN suppresses forwarding of register 0
module mips_fwd_select
  import mips_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_wreg,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_wreg,
  output logic [1:0] sel
);
  logic mem_hit, wb_hit;
`ifdef FWD_R0_GUARD_EN
  assign mem_hit = mem_regwrite && mem_wreg != '0 && mem_wreg == src;
  assign wb_hit  = wb_regwrite && wb_wreg != '0 && wb_wreg == src;
`else
  assign mem_hit = mem_regwrite && mem_wreg == src;
  assign wb_hit  = wb_regwrite && wb_wreg == src;
`endif
  // the younger EX/MEM result wins over MEM/WB
  always_comb sel = mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
endmodule

// File: rtl/mips_ctrl_fwd_unit.sv
// mips_ctrl_fwd_unit: ID decode, ID/EX control register, EX ALU control and forwarding; FWD_R0_GUARD_EN blocks forwarding from register 0
module mips_ctrl_fwd_unit
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] id_opcode,
  input  logic [5:0] id_func,
  input  logic       flush,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_wreg,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_wreg,
  output logic       id_jump,
  output logic       id_sign_zero,
  output logic       ex_regdst,
  output logic       ex_alusrc,
  output logic       ex_memtoreg,
  output logic       ex_regwrite,
  output logic       ex_memread,
  output logic       ex_memwrite,
  output logic       ex_branch,
  output logic       ex_jrcontrol,
  output logic [1:0] ex_aluop,
  output logic [1:0] alu_control,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);
  ctrl_t      id_ctrl;
  ex_ctrl_t   id_ex, ex;
  logic [5:0] ex_func;
  logic       id_jr;
  // main decode of the instruction in ID
  always_comb id_ctrl = decode(id_opcode);
  assign id_jump      = id_ctrl.jump;
  assign id_sign_zero = id_ctrl.sign_zero;
  assign id_jr        = id_ctrl.aluop == ALUOP_RTYPE && id_func == FN_JR;
  // control word headed for EX, turned into a bubble on flush
  always_comb id_ex = flush ? '0 : {id_ctrl.regdst, id_ctrl.alusrc, id_ctrl.memtoreg, id_ctrl.regwrite,
                                    id_ctrl.memread, id_ctrl.memwrite, id_ctrl.branch, id_jr, id_ctrl.aluop};
  // ID/EX control register; func is kept even through a flush
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ex      <= '0;
      ex_func <= '0;
    end else begin
      ex      <= id_ex;
      ex_func <= id_func;
    end
  assign ex_regdst    = ex.regdst;
  assign ex_alusrc    = ex.alusrc;
  assign ex_memtoreg  = ex.memtoreg;
  assign ex_regwrite  = ex.regwrite;
  assign ex_memread   = ex.memread;
  assign ex_memwrite  = ex.memwrite;
  assign ex_branch    = ex.branch;
  assign ex_jrcontrol = ex.jrcontrol;
  assign ex_aluop     = ex.aluop;
  // ALU operation; unknown R-type funcs fall back to ADD
  always_comb
    alu_control = ex.aluop == 2'b00 ? ALU_ADD :
                  ex.aluop == 2'b01 ? ALU_SUB :
                  ex.aluop == 2'b11 ? ALU_XOR :
                  ex_func == FN_ADD ? ALU_ADD :
                  ex_func == FN_SUB ? ALU_SUB :
                  ex_func == FN_SLT ? ALU_SLT :
                  ex_func == FN_XOR ? ALU_XOR : ALU_ADD;
  mips_fwd_select u_fwd_a (
    .src(ex_rs), .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
    .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg), .sel(forward_a)
  );
  mips_fwd_select u_fwd_b (
    .src(ex_rt), .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
    .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg), .sel(forward_b)
  );
endmodule

// File: tb/tb_mips_ctrl_fwd_unit.sv
// tb_mips_ctrl_fwd_unit: table-driven checks of decode, ID/EX register, ALU control and forwarding
module tb_mips_ctrl_fwd_unit;
  logic       clk = 0;
  logic       reset;
  logic [5:0] id_opcode, id_func;
  logic       flush;
  logic [4:0] ex_rs, ex_rt, mem_wreg, wb_wreg;
  logic       mem_regwrite, wb_regwrite;
  logic       id_jump, id_sign_zero;
  logic       ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jrcontrol;
  logic [1:0] ex_aluop, alu_control, forward_a, forward_b;
  logic [9:0] ex_vec;
  int         errors = 0;
  int         checks = 0;

  mips_ctrl_fwd_unit dut (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_func(id_func), .flush(flush),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
    .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg), .id_jump(id_jump), .id_sign_zero(id_sign_zero),
    .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_jrcontrol(ex_jrcontrol),
    .ex_aluop(ex_aluop), .alu_control(alu_control), .forward_a(forward_a), .forward_b(forward_b)
  );

  always #5 clk = ~clk;

  // {regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, jrcontrol, aluop}
  assign ex_vec = {ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite,
                   ex_branch, ex_jrcontrol, ex_aluop};

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       fl;
    logic       jump;
    logic       sz;
    logic [9:0] ex;
    logic [1:0] alu;
  } dec_vec_t;

  typedef struct {
    logic [4:0] rs, rt;
    logic       mrw;
    logic [4:0] mw;
    logic       wrw;
    logic [4:0] ww;
    logic [1:0] fa, fb;
  } fwd_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  dec_vec_t dv[16];
  fwd_vec_t fv[9];

  initial begin
    dv[0]  = '{6'b000000, 6'b101010, 0, 0, 0, 10'b1001000010, 2'b11};
    dv[1]  = '{6'b000000, 6'b100010, 0, 0, 0, 10'b1001000010, 2'b10};
    dv[2]  = '{6'b000000, 6'b100110, 0, 0, 0, 10'b1001000010, 2'b00};
    dv[3]  = '{6'b000000, 6'b001000, 0, 0, 0, 10'b1001000110, 2'b01};
    dv[4]  = '{6'b000000, 6'b100000, 0, 0, 0, 10'b1001000010, 2'b01};
    dv[5]  = '{6'b101011, 6'b000000, 1, 0, 0, 10'b0000000000, 2'b01};
    dv[6]  = '{6'b101011, 6'b000000, 0, 0, 0, 10'b0100010000, 2'b01};
    dv[7]  = '{6'b001110, 6'b000000, 0, 0, 1, 10'b0101000011, 2'b00};
    dv[8]  = '{6'b000010, 6'b000000, 0, 1, 0, 10'b0000000000, 2'b01};
    dv[9]  = '{6'b000101, 6'b000000, 0, 0, 0, 10'b0000001001, 2'b10};
    dv[10] = '{6'b001000, 6'b000000, 0, 0, 0, 10'b0101000000, 2'b01};
    dv[11] = '{6'b100011, 6'b000000, 0, 0, 0, 10'b0111100000, 2'b01};
    dv[12] = '{6'b111111, 6'b001000, 0, 0, 0, 10'b0000000000, 2'b01};
    dv[13] = '{6'b000010, 6'b000000, 1, 1, 0, 10'b0000000000, 2'b01};
    dv[14] = '{6'b000000, 6'b001000, 1, 0, 0, 10'b0000000000, 2'b01};
    dv[15] = '{6'b001110, 6'b100010, 1, 0, 1, 10'b0000000000, 2'b01};

    fv[0] = '{5'd5,  5'd5,  1, 5'd5,  1, 5'd5,  2'b10, 2'b10};
    fv[1] = '{5'd5,  5'd5,  0, 5'd5,  1, 5'd5,  2'b01, 2'b01};
    fv[2] = '{5'd5,  5'd5,  0, 5'd5,  1, 5'd6,  2'b00, 2'b00};
    fv[3] = '{5'd3,  5'd7,  1, 5'd3,  1, 5'd7,  2'b10, 2'b01};
    fv[4] = '{5'd7,  5'd3,  1, 5'd3,  1, 5'd7,  2'b01, 2'b10};
    fv[5] = '{5'd9,  5'd9,  0, 5'd9,  0, 5'd9,  2'b00, 2'b00};
    fv[6] = '{5'd12, 5'd13, 1, 5'd12, 1, 5'd12, 2'b10, 2'b00};
`ifdef FWD_R0_GUARD_EN
    fv[7] = '{5'd0,  5'd4,  1, 5'd0,  0, 5'd0,  2'b00, 2'b00};
    fv[8] = '{5'd0,  5'd0,  0, 5'd0,  1, 5'd0,  2'b00, 2'b00};
`else
    fv[7] = '{5'd0,  5'd4,  1, 5'd0,  0, 5'd0,  2'b10, 2'b00};
    fv[8] = '{5'd0,  5'd0,  0, 5'd0,  1, 5'd0,  2'b01, 2'b01};
`endif

    reset = 1; flush = 0; id_opcode = 6'b100011; id_func = 0;
    ex_rs = 0; ex_rt = 0; mem_regwrite = 0; mem_wreg = 0; wb_regwrite = 0; wb_wreg = 0;
    #1;
    chk("reset_ex", {22'd0, ex_vec}, 32'd0);
    chk("reset_alu", {30'd0, alu_control}, 32'h1);
    @(negedge clk) reset = 0;
    @(posedge clk) #1;
    chk("lw_after_reset_ex", {22'd0, ex_vec}, {22'd0, 10'b0111100000});
    #2 reset = 1;
    #1;
    chk("async_reset_ex", {22'd0, ex_vec}, 32'd0);
    chk("async_reset_alu", {30'd0, alu_control}, 32'h1);
    @(posedge clk) #1;
    chk("reset_holds_over_edge", {22'd0, ex_vec}, 32'd0);
    @(negedge clk) reset = 0;
    @(posedge clk) #1;
    chk("lw_release_memread", {31'd0, ex_memread}, 32'd1);
    chk("lw_release_memtoreg", {31'd0, ex_memtoreg}, 32'd1);
    chk("lw_release_alusrc", {31'd0, ex_alusrc}, 32'd1);
    chk("lw_release_aluop", {30'd0, ex_aluop}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      id_opcode = dv[i].op; id_func = dv[i].fn; flush = dv[i].fl;
      #1;
      chk($sformatf("dec%0d_jump", i), {31'd0, id_jump}, {31'd0, dv[i].jump});
      chk($sformatf("dec%0d_sign_zero", i), {31'd0, id_sign_zero}, {31'd0, dv[i].sz});
      @(posedge clk) #1;
      chk($sformatf("dec%0d_ex", i), {22'd0, ex_vec}, {22'd0, dv[i].ex});
      chk($sformatf("dec%0d_alu", i), {30'd0, alu_control}, {30'd0, dv[i].alu});
    end
    flush = 0;

    for (int i = 0; i < 9; i++) begin
      ex_rs = fv[i].rs; ex_rt = fv[i].rt;
      mem_regwrite = fv[i].mrw; mem_wreg = fv[i].mw;
      wb_regwrite = fv[i].wrw; wb_wreg = fv[i].ww;
      #1;
      chk($sformatf("fwd%0d_a", i), {30'd0, forward_a}, {30'd0, fv[i].fa});
      chk($sformatf("fwd%0d_b", i), {30'd0, forward_b}, {30'd0, fv[i].fb});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
